// File: rtl/aes_round_sequencer.sv
// Round/phase sequencer for the iterative AES-128/192/256 cipher and decipher datapath.
// Optional AES_SEQ_SINGLE_STEP_EN: advance only on rising edges of step (board button demo).
module aes_round_sequencer #(
  parameter int RW        = 5,
  parameter bit HOLD_DONE = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [1:0]    key_size,
  input  logic          decrypt,
  input  logic          ack,
  input  logic          step,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [RW-1:0] round,
  output logic [RW-1:0] rk_idx,
  output logic          load_state,
  output logic          final_round,
  output logic [RW-1:0] nr
);

  typedef enum logic [2:0] {IDLE, INIT, ROUND, LAST, DONE} state_t;

  state_t        state, state_nx;
  logic          adv;
  logic          accept;
  logic          last_adv;
  logic          dec_q, dec_nx;
  logic [3:0]    nr_sel;
  logic [RW-1:0] round_nx, rk_nx, nr_nx;

`ifdef AES_SEQ_SINGLE_STEP_EN
  logic step_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) step_q <= 1'b0;
    else        step_q <= step;
  end

  assign adv = step & ~step_q;
`else
  assign adv = step;
`endif

  assign accept   = (state == IDLE) && start && (key_size != 2'd3);
  assign nr_sel   = 4'd10 + {1'b0, key_size, 1'b0};
  assign last_adv = (round + RW'(1)) == nr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = INIT;
      INIT:    if (adv) state_nx = ROUND;
      ROUND:   if (adv && last_adv) state_nx = LAST;
      LAST:    if (adv) state_nx = DONE;
      DONE:    if (!HOLD_DONE || ack) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state == INIT) || (state == ROUND) || (state == LAST);
    done        = (state == DONE);
    load_state  = (state == INIT);
    final_round = (state == LAST);
  end

  // rk_idx is derived from the next state/round so it is registered alongside round.
  always_comb begin
    round_nx = round;
    nr_nx    = nr;
    dec_nx   = dec_q;
    if (accept) begin
      nr_nx    = RW'(nr_sel);
      dec_nx   = decrypt;
      round_nx = '0;
    end else if (adv && ((state == INIT) || (state == ROUND))) begin
      round_nx = round + RW'(1);
    end

    rk_nx = rk_idx;
    case (state_nx)
      INIT:    rk_nx = dec_nx ? nr_nx : '0;
      ROUND:   rk_nx = dec_nx ? (nr_nx - round_nx) : round_nx;
      LAST:    rk_nx = dec_nx ? '0 : nr_nx;
      default: rk_nx = rk_idx;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      round  <= '0;
      rk_idx <= '0;
      nr     <= '0;
      dec_q  <= 1'b0;
      err    <= 1'b0;
    end else begin
      round  <= round_nx;
      rk_idx <= rk_nx;
      nr     <= nr_nx;
      dec_q  <= dec_nx;
      err    <= (state == IDLE) && start && (key_size == 2'd3);
    end
  end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Randomised and directed bench for aes_round_sequencer against a position-based reference model.
module tb_aes_round_sequencer;

  localparam int RW   = 5;
  localparam bit HOLD = 1'b1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    key_size = 2'd0;
  logic          decrypt = 1'b0;
  logic          ack = 1'b0;
  logic          step = 1'b0;
  logic          busy, done, err, load_state, final_round;
  logic [RW-1:0] round, rk_idx, nr;

  aes_round_sequencer #(.RW(RW), .HOLD_DONE(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_size(key_size),
    .decrypt(decrypt), .ack(ack), .step(step), .busy(busy), .done(done),
    .err(err), .round(round), .rk_idx(rk_idx), .load_state(load_state),
    .final_round(final_round), .nr(nr)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: phase 0=idle, 1=busy, 2=done; pos 0..nr walks INIT, rounds, final round.
  int m_phase, m_pos, m_nr, m_round, m_rk;
  bit m_dec, m_err, m_prev;

  task automatic model_reset();
    m_phase = 0; m_pos = 0; m_nr = 0; m_round = 0; m_rk = 0;
    m_dec = 0; m_err = 0; m_prev = 0;
  endtask

  task automatic model_edge();
    bit a;
`ifdef AES_SEQ_SINGLE_STEP_EN
    a = step && !m_prev;
`else
    a = step;
`endif
    m_prev = step;
    m_err  = 0;
    case (m_phase)
      0: if (start) begin
        if (key_size == 2'd3) m_err = 1;
        else begin
          m_nr = 10 + 2 * int'(key_size); m_dec = decrypt; m_pos = 0;
          m_phase = 1; m_round = 0; m_rk = m_dec ? m_nr : 0;
        end
      end
      1: if (a) begin
        if (m_pos == m_nr) m_phase = 2;
        else begin
          m_pos++; m_round = m_pos; m_rk = m_dec ? m_nr - m_pos : m_pos;
        end
      end
      default: if (!HOLD || ack) m_phase = 0;
    endcase
  endtask

  always @(posedge clk) if (rst_n) model_edge();

  task automatic check_all();
    chk("busy",        32'(busy),        32'(m_phase == 1));
    chk("done",        32'(done),        32'(m_phase == 2));
    chk("err",         32'(err),         32'(m_err));
    chk("round",       32'(round),       32'(m_round));
    chk("rk_idx",      32'(rk_idx),      32'(m_rk));
    chk("nr",          32'(nr),          32'(m_nr));
    chk("load_state",  32'(load_state),  32'(m_phase == 1 && m_pos == 0));
    chk("final_round", 32'(final_round), 32'(m_phase == 1 && m_pos == m_nr));
  endtask

  task automatic cycle();
    @(negedge clk);
    check_all();
  endtask

  // Start an op and advance until done; mode 0 step high, 1 alternating, 2 random.
  task automatic run_op(input logic [1:0] ks, input logic dec, input int mode, input int exp_lat);
    int lat;
    key_size = ks; decrypt = dec; ack = 1'b0; start = 1'b1;
    step = (mode == 0) ? 1'b1 : 1'b0;
    cycle();
    lat = 1; start = 1'b0;
    while (!done && lat < 200) begin
      if (mode == 1) step = ~step;
      else if (mode == 2) step = ($urandom_range(0, 2) != 0);
`ifdef AES_SEQ_SINGLE_STEP_EN
      else step = ~step;
`endif
      key_size = 2'($urandom); decrypt = 1'($urandom);
      cycle();
      lat++;
    end
    chk("done_reached", 32'(done), 32'd1);
`ifndef AES_SEQ_SINGLE_STEP_EN
    if (exp_lat > 0) chk("latency", 32'(lat), 32'(exp_lat));
`endif
  endtask

  task automatic handshake();
    ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      start = 1'b1; key_size = 2'd0;
      cycle();
    end
    ack = 1'b1;
    cycle();
    ack = 1'b0; start = 1'b0;
    cycle();
  endtask

  initial begin
    model_reset();
    #12;
    check_all();
    rst_n = 1'b1;
    @(negedge clk);

    run_op(2'd0, 1'b0, 0, 12);
    handshake();
    run_op(2'd2, 1'b1, 0, 16);
    handshake();

    key_size = 2'd3; start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();

    run_op(2'd1, 1'b0, 1, 0);
    handshake();
    run_op(2'd1, 1'b1, 2, 0);
    handshake();

    key_size = 2'd0; decrypt = 1'b0; step = 1'b1; start = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 40 && m_round != 5; i++) begin
`ifdef AES_SEQ_SINGLE_STEP_EN
      step = ~step;
`endif
      cycle();
    end
    chk("pre_reset_round", 32'(round), 32'd5);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    cycle();
    #2;
    rst_n = 1'b1;
    cycle();
    run_op(2'd0, 1'b1, 0, 12);
    handshake();

    for (int i = 0; i < 3000; i++) begin
      start    = ($urandom_range(0, 3) == 0);
      key_size = 2'($urandom);
      decrypt  = 1'($urandom);
      step     = ($urandom_range(0, 3) != 0);
      ack      = ($urandom_range(0, 7) == 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
